// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned STARVE_W   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is hardwired to zero, so a write to it must never reach the file.
  function automatic logic is_writable(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester, load-return, and register-file write-port signals of the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                  wb_valid_i;
  logic                  wb_ready_o;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic [XLEN-1:0]       wb_data_i;
  logic                  lr_valid_i;
  logic                  lr_ready_o;
  logic [REG_ADDR_W-1:0] lr_rd_i;
  logic [XLEN-1:0]       lr_data_i;
  logic                  lr_issue_i;
  logic [REG_ADDR_W-1:0] lr_issue_rd_i;
  logic                  write_en_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]       reg_wr_data_o;
  logic [NUM_REGS-1:0]   busy_o;

  modport slave (
    input  wb_valid_i, wb_rd_i, wb_data_i, lr_valid_i, lr_rd_i, lr_data_i,
           lr_issue_i, lr_issue_rd_i,
    output wb_ready_o, lr_ready_o, write_en_o, rd_addr_o, reg_wr_data_o, busy_o
  );

  modport master (
    output wb_valid_i, wb_rd_i, wb_data_i, lr_valid_i, lr_rd_i, lr_data_i,
           lr_issue_i, lr_issue_rd_i,
    input  wb_ready_o, lr_ready_o, write_en_o, rd_addr_o, reg_wr_data_o, busy_o
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy vector of registers with an outstanding long-latency write; a set in the
// same cycle as a clear of the same register wins, since the new load is pending.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  output logic [NUM_REGS-1:0]   busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_rd_i] = 1'b0;
    if (set_en_i && is_writable(set_rd_i)) busy_d[set_rd_i] = 1'b1;
  end

  // NOTE: this vector is control state the hazard logic trusts, so unlike a data
  // array it must be reset; stale busy bits after reset would stall forever.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's write port between pipeline writeback and load return.
// Define REGFILE_ARB_SCOREBOARD_EN to build the outstanding-load busy scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                write_en_q, write_en_d;
  wb_req_t             out_q, out_d;
  wb_req_t             wb_req, lr_req;
  logic                force_lr, wb_fire, lr_fire;

  assign wb_req = '{rd: bus.wb_rd_i, data: bus.wb_data_i};
  assign lr_req = '{rd: bus.lr_rd_i, data: bus.lr_data_i};

  // WB has priority until LR has waited STARVE_LIMIT cycles; the grants are exclusive.
  assign force_lr       = (starve_cnt_q == LIMIT) && bus.lr_valid_i;
  assign bus.wb_ready_o = !force_lr;
  assign bus.lr_ready_o = force_lr || !bus.wb_valid_i;
  assign wb_fire        = bus.wb_valid_i && bus.wb_ready_o;
  assign lr_fire        = bus.lr_valid_i && bus.lr_ready_o;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.lr_valid_i || lr_fire) starve_cnt_d = '0;
    else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;

    write_en_d = 1'b0;
    out_d      = out_q;
    if (wb_fire) begin
      out_d      = wb_req;
      write_en_d = is_writable(wb_req.rd);
    end else if (lr_fire) begin
      out_d      = lr_req;
      write_en_d = is_writable(lr_req.rd);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
      write_en_q   <= 1'b0;
      out_q        <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      write_en_q   <= write_en_d;
      out_q        <= out_d;
    end
  end

  assign bus.write_en_o    = write_en_q;
  assign bus.rd_addr_o     = out_q.rd;
  assign bus.reg_wr_data_o = out_q.data;

`ifdef REGFILE_ARB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set_en_i (bus.lr_issue_i),
    .set_rd_i (bus.lr_issue_rd_i),
    .clr_en_i (lr_fire),
    .clr_rd_i (bus.lr_rd_i),
    .busy_o   (bus.busy_o)
  );
`else
  logic unused_issue;
  assign unused_issue = ^{bus.lr_issue_i, bus.lr_issue_rd_i};
  assign bus.busy_o   = '0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32x32 integer register file. It shares the file's single write port between two writeback sources: the in-order pipeline writeback (WB) and the long-latency load-return path (LR). A starvation counter bounds how long LR can be locked out. Optionally, it tracks registers that have an outstanding long-latency write so the hazard logic can stall on them. It sits between the writeback stage and the register file's write_en/rd_addr/wr_data inputs.

## Interface
- STARVE_LIMIT, 4: consecutive cycles LR may wait with valid high before it is forced to win; legal range 1..15.
- clk_i  in  1  core clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- wb_valid_i  in  1  pipeline writeback request.
- wb_ready_o  out  1  WB request accepted this cycle.
- wb_rd_i  in  5  WB destination register.
- wb_data_i  in  32  WB write data.
- lr_valid_i  in  1  load-return writeback request.
- lr_ready_o  out  1  LR request accepted this cycle.
- lr_rd_i  in  5  LR destination register.
- lr_data_i  in  32  LR write data.
- lr_issue_i  in  1  a long-latency load to lr_issue_rd_i has been issued.
- lr_issue_rd_i  in  5  destination of the issued load.
- write_en_o  out  1  register-file write enable, registered.
- rd_addr_o  out  5  register-file write address, registered.
- reg_wr_data_o  out  32  register-file write data, registered.
- busy_o  out  32  bit n = 1 means register n has an outstanding LR write.

## Operation
- Handshake: a transfer occurs on any cycle where valid && ready. A requester holds its rd and data stable while valid is high and ready is low.
- Ready signals are combinational from the valids and internal state:
  - force_lr = (starve_cnt == STARVE_LIMIT) && lr_valid_i.
  - wb_ready_o = !force_lr.
  - lr_ready_o = force_lr || !wb_valid_i.
- At most one transfer per cycle.
- starve_cnt, width 4:
  - Increments when lr_valid_i && !lr_ready_o.
  - Clears on LR transfer or when lr_valid_i = 0.
  - Never exceeds STARVE_LIMIT.
- On a transfer, the next cycle presents the winner's rd/data on rd_addr_o/reg_wr_data_o. write_en_o = 1 only if that rd != 0.
  - A write to x0 still completes the handshake.
  - write_en_o is 0 on idle cycles.
  - rd_addr_o and reg_wr_data_o hold their last values when idle.
- Scoreboard (see Configuration):
  - lr_issue_i with rd != 0 sets busy[rd].
  - An LR transfer clears busy[lr_rd_i].
  - Issue and LR retire to the same rd in the same cycle: the bit ends at 1, because the new load is outstanding.
  - An issue to x0 is ignored.
  - WB transfers never touch busy.

## Timing
- Acceptance to write_en_o: 1 cycle. The register file commits on the following edge, so data is readable 2 edges after acceptance.
- Sustained throughput: 1 write per cycle.
- Worst-case LR wait with WB saturated: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.
- Reset (rst_ni low, any cycle including mid-transfer):
  - write_en_o = 0, rd_addr_o = 0, reg_wr_data_o = 0, busy_o = 0, starve_cnt = 0.
  - An in-flight registered write is dropped.
  - Ready outputs follow the combinational rules with starve_cnt = 0.
- First transfer is possible in the first cycle after rst_ni deasserts.

## Configuration
- REGFILE_ARB_SCOREBOARD_EN defined: the busy scoreboard is built as described above.
- Undefined:
  - busy_o is tied to 32'd0.
  - lr_issue_i and lr_issue_rd_i are ignored.
  - No scoreboard flops are generated.
  - Arbitration and write timing are unchanged.

## Structure
- Shared package regfile_pkg holds:
  - REG_ADDR_W = 5, XLEN = 32, NUM_REGS = 32.
  - typedef wb_req_t {rd, data}.
- One sub-module, wb_scoreboard: busy vector with set/clear ports, instantiated only under REGFILE_ARB_SCOREBOARD_EN.
- Arbitration, starvation counter and output register stay in the top module.

## Test plan
- WB only, write rd=5 data=0xDEADBEEF: wb_ready_o=1; next cycle write_en_o=1, rd_addr_o=5, reg_wr_data_o=0xDEADBEEF; the following cycle write_en_o=0.
- Both valid, WB held continuously, LR rd=7 data=0x11, STARVE_LIMIT=4:
  - WB wins cycles 1–4.
  - Cycle 5: lr_ready_o=1, wb_ready_o=0.
  - Cycle 6: rd_addr_o=7, data 0x11, and starve_cnt=0.
- WB write to rd=0 data=0xFFFFFFFF: wb_ready_o=1; next cycle write_en_o=0.
- Scoreboard:
  - lr_issue rd=9 sets busy_o=0x200.
  - An LR transfer with rd=9 clears it the next cycle.
  - Issue rd=9 together with an LR retire of rd=9 leaves busy_o=0x200.
- Reset: assert rst_ni low asynchronously between edges while write_en_o=1 and busy_o=0x200. All outputs go to 0 immediately, without waiting for a clock edge, and no write occurs.
- With REGFILE_ARB_SCOREBOARD_EN undefined: lr_issue rd=3 leaves busy_o=0, and arbitration results are identical to the first two scenarios.
